action_reset_sequencer: RTL and testbench
=========================================

// Module: action_reset_sequencer
// PURPOSE
// Multi-domain reset sequencer for action entities; successor to the single-chain reset handler.
// After the initial reset duty cycle, releases domains 0..N-1 in order, gating each on its predecessor's ready.
// Adds: configurable inter-domain hold time, per-domain ready timeout with fault reporting,
// and per-domain soft restart without a full system reset. Sits between the system reset request and the action's reset domains.
// PARAMETERS
// ResetDomains       4    number of reset domains (>=1)
// DomainIndexSize    2    width of domain index; 2**DomainIndexSize >= ResetDomains
// ResetDutyCycle     15   initial/restart duty-cycle load value, in clocks
// ResetCounterSize   4    duty counter width; must hold ResetDutyCycle
// DomainHoldCycles   2    clocks between ready of domain i and release of domain i+1 (0 allowed)
// ReadyTimeout       255  clocks allowed for a released domain to assert ready; 0 disables timeout
// TimeoutCounterSize 8    width of the hold/timeout counter; must hold max(ReadyTimeout, DomainHoldCycles)
// PORTS
// clk           in   1                 clock; sole clock domain
// sysRstReq     in   1                 synchronous, active-high reset; restarts the full sequence
// domainRst     out  ResetDomains      per-domain reset, active-high; bit 0 released first
// domainRdy     in   ResetDomains      per-domain ready, level-sensitive
// domainRstReq  in   ResetDomains      per-domain soft restart request, sampled each clock
// sysResetDone  out  1                 high when all domains are released and ready
// resetFault    out  1                 sticky ready-timeout flag
// faultDomain   out  DomainIndexSize   index of the timed-out domain
// BEHAVIOUR
// - Reset (sysRstReq sampled high) or bitstream init:
//   - state=INIT, duty counter=ResetDutyCycle, startIdx=0.
//   - domainRst=all 1s; sysResetDone=0; resetFault=0; faultDomain=0.
//   - domainRst init value is all 1s, so domains are held in reset from load.
// - All outputs are registered; every transition below takes effect on the sampling edge.
// - INIT: duty counter decrements each clock. At 0: clear domainRst[startIdx], load timeout counter, go RELEASE(idx=startIdx).
//   => after a full reset, domainRst[0] falls on edge ResetDutyCycle+1 after the last edge that sampled sysRstReq high.
// - RELEASE(idx): domain idx is released at edge r; domainRdy[idx] is sampled from r+1.
//   - Ready sampled high at edge t, idx==N-1: sysResetDone=1 at t, go DONE.
//   - Ready sampled high at edge t, idx<N-1, DomainHoldCycles==0: domainRst[idx+1] falls at t; go RELEASE(idx+1).
//   - Ready sampled high at edge t, idx<N-1, DomainHoldCycles>0: go HOLD; domainRst[idx+1] falls at t+DomainHoldCycles, then RELEASE(idx+1).
//   - Ready not seen by edge r+ReadyTimeout (ReadyTimeout!=0): at that edge resetFault=1, faultDomain=idx,
//     domainRst[idx] re-asserted, go FAULT.
//   - Ready sampled high on the expiry edge wins over timeout.
// - HOLD: domainRdy is not re-checked; a ready drop during HOLD is ignored.
// - DONE: all domainRst=0; domainRdy changes are ignored; remains DONE until sysRstReq or a soft request.
// - FAULT: domains < faultDomain stay released; domains >= faultDomain are held in reset. Exit only via sysRstReq or a soft request.
// - Soft restart:
//   - j = lowest set bit of domainRstReq.
//   - Acted on if domain j has been released: state DONE or FAULT, or j <= current idx in RELEASE/HOLD.
//   - Effect at the sampling edge:
//     - domainRst[N-1:j] = all 1s; sysResetDone=0; resetFault=0.
//     - duty counter=ResetDutyCycle; startIdx=j; go INIT.
//   - Domains < j are untouched.
//   - Otherwise (INIT, or j > idx) the request is ignored.
// - Priority: sysRstReq > soft restart > ready > timeout/hold expiry.
// - Soft restart during INIT (including a restart's own INIT) is ignored; the duty count is not reloaded.
// - Counters never wrap: they saturate at 0 and are reloaded only as stated.
// TESTING (N=4, ResetDutyCycle=15, DomainHoldCycles=2, ReadyTimeout=8; sysRstReq high at edge 0 only)
// 1 Full sequence:
//   - domainRst[0] falls at edge 16; rdy[0] high from edge 20, so domainRst[1] falls at edge 22.
//   - Repeat through domain 3; sysResetDone=1 on the edge that samples rdy[3] high.
// 2 Timeout:
//   - domainRst[1] released at edge r; rdy[1] held low.
//   - At r+8: resetFault=1, faultDomain=1, domainRst=4'b1110.
//   - domainRst[0] stays 0 afterwards.
// 3 Ready on expiry edge: rdy[1] first high at r+8 -> no fault; sequence proceeds.
// 4 Soft restart from DONE:
//   - domainRstReq=4'b0100 for 1 clock at edge s.
//   - At s: domainRst=4'b1100, sysResetDone=0.
//   - domainRst[2] falls at s+16; the sequence then completes again.
// 5 Ignored / priority:
//   - domainRstReq=4'b1000 while in RELEASE(1) -> no effect.
//   - sysRstReq and domainRstReq both high at one edge -> full reset: domainRst=4'b1111, startIdx=0.
// 6 Reset mid-operation: sysRstReq during HOLD or FAULT -> domainRst=4'b1111, resetFault=0; sequence 1 repeats.

Source files
------------

// File: rtl/action_reset_sequencer.sv
// Multi-domain reset sequencer: after the duty cycle, releases reset domains
// in index order. Each domain is gated on its predecessor's ready, with an
// optional hold gap between domains, a per-domain ready timeout that raises a
// sticky fault, and per-domain soft restart.
module action_reset_sequencer #(
  parameter int unsigned ResetDomains       = 4,
  parameter int unsigned DomainIndexSize    = 2,
  parameter int unsigned ResetDutyCycle     = 15,
  parameter int unsigned ResetCounterSize   = 4,
  parameter int unsigned DomainHoldCycles   = 2,
  parameter int unsigned ReadyTimeout       = 255,
  parameter int unsigned TimeoutCounterSize = 8
) (
  input  logic                       clk,
  input  logic                       sysRstReq,
  output logic [ResetDomains-1:0]    domainRst,
  input  logic [ResetDomains-1:0]    domainRdy,
  input  logic [ResetDomains-1:0]    domainRstReq,
  output logic                       sysResetDone,
  output logic                       resetFault,
  output logic [DomainIndexSize-1:0] faultDomain
);

  localparam logic [ResetCounterSize-1:0]   DutyLoad = ResetCounterSize'(ResetDutyCycle);
  localparam logic [TimeoutCounterSize-1:0] TmoLoad  = TimeoutCounterSize'(ReadyTimeout);
  localparam logic [TimeoutCounterSize-1:0] HoldLoad = TimeoutCounterSize'(DomainHoldCycles);
  localparam logic [DomainIndexSize-1:0]    LastIdx  = DomainIndexSize'(ResetDomains - 1);

  typedef enum logic [2:0] {
    StInit,
    StRelease,
    StHold,
    StDone,
    StFault
  } stateT;

  stateT                         state, stateNext;
  logic [ResetCounterSize-1:0]   dutyCnt, dutyCntNext;
  logic [TimeoutCounterSize-1:0] tmoCnt, tmoCntNext;
  logic [DomainIndexSize-1:0]    idx, idxNext, idxInc;
  logic [ResetDomains-1:0]       domainRstNext;
  logic                          sysResetDoneNext;
  logic                          resetFaultNext;
  logic [DomainIndexSize-1:0]    faultDomainNext;

  logic                          softHit;
  logic                          softOk;
  logic [DomainIndexSize-1:0]    softIdx;
  logic [ResetDomains-1:0]       softMask;

  assign idxInc = idx + DomainIndexSize'(1);

  // Lowest requested soft-restart domain and the mask of domains it re-resets.
  always_comb begin
    softHit  = 1'b0;
    softIdx  = '0;
    softMask = '0;
    for (int unsigned i = 0; i < ResetDomains; i++) begin
      if (!softHit && domainRstReq[i]) begin
        softHit = 1'b1;
        softIdx = DomainIndexSize'(i);
      end
    end
    for (int unsigned i = 0; i < ResetDomains; i++) begin
      if (i >= 32'(softIdx)) softMask[i] = 1'b1;
    end
    softOk = softHit &&
             ((state == StDone) || (state == StFault) ||
              (((state == StRelease) || (state == StHold)) && (softIdx <= idx)));
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext        = state;
    dutyCntNext      = dutyCnt;
    tmoCntNext       = tmoCnt;
    idxNext          = idx;
    domainRstNext    = domainRst;
    sysResetDoneNext = sysResetDone;
    resetFaultNext   = resetFault;
    faultDomainNext  = faultDomain;

    if (softOk) begin
      domainRstNext    = domainRst | softMask;
      sysResetDoneNext = 1'b0;
      resetFaultNext   = 1'b0;
      dutyCntNext      = DutyLoad;
      idxNext          = softIdx;
      stateNext        = StInit;
    end else begin
      case (state)
        StInit: begin
          if (dutyCnt == '0) begin
            domainRstNext[idx] = 1'b0;
            tmoCntNext         = TmoLoad;
            stateNext          = StRelease;
          end else begin
            dutyCntNext = dutyCnt - ResetCounterSize'(1);
          end
        end
        StRelease: begin
          if (domainRdy[idx]) begin
            if (idx == LastIdx) begin
              sysResetDoneNext = 1'b1;
              stateNext        = StDone;
            end else if (DomainHoldCycles == 0) begin
              domainRstNext[idxInc] = 1'b0;
              idxNext               = idxInc;
              tmoCntNext            = TmoLoad;
            end else begin
              tmoCntNext = HoldLoad;
              stateNext  = StHold;
            end
          end else if ((ReadyTimeout != 0) && (tmoCnt <= TimeoutCounterSize'(1))) begin
            resetFaultNext     = 1'b1;
            faultDomainNext    = idx;
            domainRstNext[idx] = 1'b1;
            stateNext          = StFault;
          end else if (tmoCnt != '0) begin
            tmoCntNext = tmoCnt - TimeoutCounterSize'(1);
          end
        end
        StHold: begin
          if (tmoCnt <= TimeoutCounterSize'(1)) begin
            domainRstNext[idxInc] = 1'b0;
            idxNext               = idxInc;
            tmoCntNext            = TmoLoad;
            stateNext             = StRelease;
          end else begin
            tmoCntNext = tmoCnt - TimeoutCounterSize'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers; sysRstReq restarts the whole sequence.
  always_ff @(posedge clk) begin
    if (sysRstReq) begin
      state        <= StInit;
      dutyCnt      <= DutyLoad;
      tmoCnt       <= '0;
      idx          <= '0;
      domainRst    <= '1;
      sysResetDone <= 1'b0;
      resetFault   <= 1'b0;
      faultDomain  <= '0;
    end else begin
      state        <= stateNext;
      dutyCnt      <= dutyCntNext;
      tmoCnt       <= tmoCntNext;
      idx          <= idxNext;
      domainRst    <= domainRstNext;
      sysResetDone <= sysResetDoneNext;
      resetFault   <= resetFaultNext;
      faultDomain  <= faultDomainNext;
    end
  end

endmodule

// File: tb/tb_action_reset_sequencer.sv
// Bench for action_reset_sequencer: timestamp-based reference model checked
// every cycle, plus hand-computed expectations at key edges.
module tb_action_reset_sequencer;

  localparam int N    = 4;
  localparam int Duty = 15;
  localparam int Hold = 2;
  localparam int Tmo  = 8;

  localparam int MInit = 0, MRel = 1, MHold = 2, MDone = 3, MFault = 4;

  logic       clk;
  logic       sysRstReq;
  logic [3:0] domainRst;
  logic [3:0] domainRdy;
  logic [3:0] domainRstReq;
  logic       sysResetDone;
  logic       resetFault;
  logic [1:0] faultDomain;

  int errors = 0;
  int checks = 0;
  int cyc    = -1;

  // Model state: phases keyed by absolute edge numbers.
  int         mMode, mIdx, mInitRel, mRelEdge, mHoldEnd;
  logic [3:0] mRst;
  logic       mDone, mFault;
  logic [1:0] mFdom;

  action_reset_sequencer #(
    .ResetDomains(4), .DomainIndexSize(2), .ResetDutyCycle(Duty),
    .ResetCounterSize(4), .DomainHoldCycles(Hold), .ReadyTimeout(Tmo),
    .TimeoutCounterSize(8)
  ) dut (
    .clk(clk), .sysRstReq(sysRstReq), .domainRst(domainRst),
    .domainRdy(domainRdy), .domainRstReq(domainRstReq),
    .sysResetDone(sysResetDone), .resetFault(resetFault),
    .faultDomain(faultDomain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model, advanced on every edge with the inputs the DUT samples.
  always @(posedge clk) begin
    int j;
    cyc = cyc + 1;
    if (sysRstReq) begin
      mMode = MInit; mIdx = 0; mInitRel = cyc + Duty + 1;
      mRst = 4'b1111; mDone = 1'b0; mFault = 1'b0; mFdom = 2'd0;
    end else begin
      j = -1;
      for (int i = 0; i < N; i++) if (j < 0 && domainRstReq[i]) j = i;
      if (j >= 0 && (mMode == MDone || mMode == MFault ||
                     ((mMode == MRel || mMode == MHold) && j <= mIdx))) begin
        for (int i = 0; i < N; i++) if (i >= j) mRst[i] = 1'b1;
        mDone = 1'b0; mFault = 1'b0; mIdx = j;
        mInitRel = cyc + Duty + 1; mMode = MInit;
      end else begin
        case (mMode)
          MInit: if (cyc == mInitRel) begin
            mRst[mIdx] = 1'b0; mRelEdge = cyc; mMode = MRel;
          end
          MRel: begin
            if (domainRdy[mIdx]) begin
              if (mIdx == N - 1) begin
                mDone = 1'b1; mMode = MDone;
              end else begin
                mHoldEnd = cyc + Hold; mMode = MHold;
              end
            end else if (cyc == mRelEdge + Tmo) begin
              mFault = 1'b1; mFdom = 2'(mIdx); mRst[mIdx] = 1'b1; mMode = MFault;
            end
          end
          MHold: if (cyc == mHoldEnd) begin
            mIdx = mIdx + 1; mRst[mIdx] = 1'b0; mRelEdge = cyc; mMode = MRel;
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      chk("model_domainRst", 32'(domainRst), 32'(mRst));
      chk("model_sysResetDone", 32'(sysResetDone), 32'(mDone));
      chk("model_resetFault", 32'(resetFault), 32'(mFault));
      chk("model_faultDomain", 32'(faultDomain), 32'(mFdom));
    end
  end

  // Wait to the negedge just before edge n, so drives are sampled at edge n.
  task automatic at(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  // Wait to the negedge just after edge n.
  task automatic after(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    sysRstReq = 1'b1; domainRdy = 4'b0000; domainRstReq = 4'b0000;
    at(1);   sysRstReq = 1'b0;
    // Full sequence
    after(15);  chk("rst_before_release", 32'(domainRst), 32'h0000000f);
    after(16);  chk("rst0_release", 32'(domainRst), 32'h0000000e);
    at(20);     domainRdy = 4'b0001;
    after(21);  chk("hold_gap", 32'(domainRst), 32'h0000000e);
    after(22);  chk("rst1_release", 32'(domainRst), 32'h0000000c);
    at(25);     domainRdy = 4'b0011;
    after(27);  chk("rst2_release", 32'(domainRst), 32'h00000008);
    at(30);     domainRdy = 4'b0111;
    after(32);  chk("rst3_release", 32'(domainRst), 32'h00000000);
    after(34);  chk("done_pending", 32'(sysResetDone), 32'h0);
    at(35);     domainRdy = 4'b1111;
    after(35);  chk("done_set", 32'(sysResetDone), 32'h1);
    // Soft restart from DONE
    at(40);     domainRstReq = 4'b0100;
    after(40);  chk("soft_rst", 32'(domainRst), 32'h0000000c);
                chk("soft_done_clr", 32'(sysResetDone), 32'h0);
    at(41);     domainRstReq = 4'b0000;
    after(55);  chk("soft_init_hold", 32'(domainRst), 32'h0000000c);
    after(56);  chk("soft_rst2_release", 32'(domainRst), 32'h00000008);
    after(59);  chk("soft_rst3_release", 32'(domainRst), 32'h00000000);
    after(60);  chk("soft_done", 32'(sysResetDone), 32'h1);
    // Full reset, then timeout on domain 1
    at(65);     sysRstReq = 1'b1; domainRdy = 4'b0000;
    after(65);  chk("reset_from_done", 32'(domainRst), 32'h0000000f);
    at(66);     sysRstReq = 1'b0;
    at(83);     domainRdy = 4'b0001;
    after(85);  chk("to_rst1_release", 32'(domainRst), 32'h0000000c);
    at(88);     domainRstReq = 4'b1000;
    after(88);  chk("ignored_soft", 32'(domainRst), 32'h0000000c);
    at(89);     domainRstReq = 4'b0000;
    after(92);  chk("no_fault_yet", 32'(resetFault), 32'h0);
    after(93);  chk("fault_set", 32'(resetFault), 32'h1);
                chk("fault_domain", 32'(faultDomain), 32'h1);
                chk("fault_rst", 32'(domainRst), 32'h0000000e);
    after(97);  chk("fault_rst0_kept", 32'(domainRst), 32'h0000000e);
    // Reset and soft request together during FAULT
    at(100);    sysRstReq = 1'b1; domainRstReq = 4'b0010; domainRdy = 4'b0000;
    after(100); chk("prio_rst", 32'(domainRst), 32'h0000000f);
                chk("prio_fault_clr", 32'(resetFault), 32'h0);
                chk("prio_fdom_clr", 32'(faultDomain), 32'h0);
    at(101);    sysRstReq = 1'b0; domainRstReq = 4'b0000;
    // Ready exactly on the expiry edge
    at(118);    domainRdy = 4'b0001;
    after(120); chk("exp_rst1_release", 32'(domainRst), 32'h0000000c);
    at(128);    domainRdy = 4'b0011;
    after(128); chk("expiry_ready_wins", 32'(resetFault), 32'h0);
    after(130); chk("expiry_rst2_release", 32'(domainRst), 32'h00000008);
    // Reset during HOLD
    at(132);    domainRdy = 4'b0111;
    at(133);    sysRstReq = 1'b1; domainRdy = 4'b0000;
    after(133); chk("hold_reset", 32'(domainRst), 32'h0000000f);
    at(134);    sysRstReq = 1'b0;
    after(149); chk("rerun_rst0", 32'(domainRst), 32'h0000000e);
    // Soft restart of domain 0 in RELEASE(0), then ignored during INIT
    at(151);    domainRstReq = 4'b0001;
    after(151); chk("soft_rel0", 32'(domainRst), 32'h0000000f);
    at(152);    domainRstReq = 4'b0000;
    at(155);    domainRstReq = 4'b0001;
    at(156);    domainRstReq = 4'b0000;
    at(161);    domainRdy = 4'b1111;
    after(166); chk("init_soft_ignored", 32'(domainRst), 32'h0000000f);
    after(167); chk("restart_rst0", 32'(domainRst), 32'h0000000e);
    after(176); chk("restart_rst3", 32'(domainRst), 32'h00000000);
    after(177); chk("restart_done", 32'(sysResetDone), 32'h1);
    after(185); chk("done_stable", 32'(sysResetDone), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
